// File: rtl/spi_capture_slave.sv
// rtl/spi_capture_slave.sv - SPI-slave logic capture: pin sampler, sample FIFO, SPI mode-0 drain port
// Define SPI_STATUS_EN to add the STATUS command (0x04).
module spi_capture_slave #(
  parameter int CHANNELS    = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DIV  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        pin_values,
  input  logic                       spi_clk,
  input  logic                       mosi,
  input  logic                       spi_cs_n,
  output logic                       miso,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int NB = CHANNELS / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [1:0] {
    ST_CMD,
`ifdef SPI_STATUS_EN
    ST_STATUS,
`endif
    ST_STREAM
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   cs_active;
  logic                   sck_prev;
  logic                   sck_filt;
  logic                   sck_filt_d;
  logic                   sck_rise;
  logic                   sck_fall;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [7:0]             rx_byte;
  logic [7:0]             tx_shift;
  logic [7:0]             tx_load_byte;
  logic [KW-1:0]          byte_idx;
  logic [KW-1:0]          next_idx;
  logic [CHANNELS-1:0]    hold;
  logic [CHANNELS-1:0]    next_hold;
  logic [7:0]             hold_bytes [2**KW];

  logic [CHANNELS-1:0]    mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_nxt;
  logic [PW-1:0]          rd_nxt;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   drop;

  logic                   armed;
  logic [DW-1:0]          div_cnt;
  logic                   tick;
  logic                   byte_done;
  logic                   load_data;
  logic                   arm_cmd;
  logic                   disarm_cmd;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_active = ~cs_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_filt & ~sck_filt_d;
  assign sck_fall  = ~sck_filt & sck_filt_d;

  assign rx_byte    = {rx_shift, mosi_s};
  assign byte_done  = cs_active && sck_rise && (bit_cnt == 3'd7);
  assign arm_cmd    = byte_done && (state == ST_CMD) && (rx_byte == 8'h01);
  assign disarm_cmd = byte_done && (state == ST_CMD) && (rx_byte == 8'h02);
  assign load_data  = byte_done &&
                      (((state == ST_CMD) && (rx_byte == 8'h03)) || (state == ST_STREAM));

  // Byte index restarts at 0 on the READ boundary and after the last byte of a sample.
  assign next_idx = ((state != ST_STREAM) || (byte_idx == KW'(NB - 1))) ? '0 : byte_idx + KW'(1);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tick  = armed && (div_cnt == DW'(SAMPLE_DIV - 1));
  assign pop   = load_data && (next_idx == '0) && !empty;
  assign push  = tick && (!full || pop);
  assign drop  = tick && full && !pop;
  assign wr_nxt = wr_ptr + PW'(push);
  assign rd_nxt = rd_ptr + PW'(pop);

  assign next_hold = (next_idx != '0) ? hold : (empty ? '0 : mem[rd_ptr[AW-1:0]]);

  for (genvar i = 0; i < 2**KW; i++) begin : g_bytes
    if (i < NB) begin : g_used
      assign hold_bytes[i] = next_hold[CHANNELS-1-8*i -: 8];
    end else begin : g_pad
      assign hold_bytes[i] = 8'h00;
    end
  end

  assign tx_load_byte = hold_bytes[next_idx];

`ifdef SPI_STATUS_EN
  logic [7:0] status_byte;
  assign status_byte = {overflow, armed, 6'(fifo_level)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync   <= '0;
      mosi_sync  <= '0;
      cs_sync    <= '1;
      sck_prev   <= 1'b0;
      sck_filt   <= 1'b0;
      sck_filt_d <= 1'b0;
      state      <= ST_CMD;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      byte_idx   <= '0;
      hold       <= '0;
      miso       <= 1'b0;
      armed      <= 1'b0;
      overflow   <= 1'b0;
      div_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};

      // Filtered SCK follows only after two equal synchronised samples in a row.
      sck_prev <= sck_s;
      if (sck_s == sck_prev) sck_filt <= sck_s;
      sck_filt_d <= sck_filt;

      if (arm_cmd) begin
        armed   <= 1'b1;
        div_cnt <= '0;
      end else begin
        div_cnt <= (div_cnt == DW'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DW'(1);
        if (disarm_cmd) armed <= 1'b0;
      end

      if (arm_cmd) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;

      if (push) mem[wr_ptr[AW-1:0]] <= pin_values;
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      fifo_level <= LW'(wr_nxt - rd_nxt);

      if (!cs_active) begin
        state    <= ST_CMD;
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        byte_idx <= '0;
        miso     <= 1'b0;
      end else if (sck_rise) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (load_data) begin
          byte_idx <= next_idx;
          hold     <= next_hold;
          tx_shift <= tx_load_byte;
        end
        if (byte_done && (state == ST_CMD) && (rx_byte == 8'h03)) state <= ST_STREAM;
`ifdef SPI_STATUS_EN
        if (byte_done && (((state == ST_CMD) && (rx_byte == 8'h04)) || (state == ST_STATUS))) begin
          state    <= ST_STATUS;
          tx_shift <= status_byte;
        end
`endif
      end else if (sck_fall) begin
        miso     <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_capture_slave.sv
// tb/tb_spi_capture_slave.sv - randomized self-checking bench for spi_capture_slave
// Reference model is a sample queue plus an overflow flag, driven by the bench's own SPI timing.
module tb_spi_capture_slave;

  localparam int CH   = 16;
  localparam int DEP  = 16;
  localparam int SYNC = 2;
  localparam int DIV  = 16;
  localparam int NB   = CH / 8;
  localparam int H    = 8;
  localparam int LW   = $clog2(DEP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] pin_values = '0;
  logic          spi_clk = 1'b0;
  logic          mosi = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          miso;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rise = 0;

  logic [CH-1:0] mq[$];
  bit            movf = 1'b0;

  spi_capture_slave #(
    .CHANNELS(CH), .DEPTH(DEP), .SYNC_STAGES(SYNC), .SAMPLE_DIV(DIV)
  ) dut (
    .clk(clk), .rst(rst), .pin_values(pin_values), .spi_clk(spi_clk), .mosi(mosi),
    .spi_cs_n(spi_cs_n), .miso(miso), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, 32'(fifo_level), 32'(mq.size()));
    check({tag, "_ovf"}, 32'(overflow), 32'(movf));
  endtask

  // One SPI mode-0 byte (or fewer bits); optional 1-clk SCK glitches in the low and high phases.
  task automatic spi_byte(input logic [7:0] b, input int nbits, input bit glitch, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      if (glitch && i == 3) begin
        wait_clk(3); spi_clk = 1'b1; wait_clk(1); spi_clk = 1'b0; wait_clk(H - 4);
      end else begin
        wait_clk(H);
      end
      rx = {rx[6:0], miso};
      spi_clk = 1'b1;
      last_rise = cyc;
      if (glitch && i == 5) begin
        wait_clk(3); spi_clk = 1'b0; wait_clk(1); spi_clk = 1'b1; wait_clk(H - 4);
      end else begin
        wait_clk(H);
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    wait_clk(H);
    spi_cs_n = 1'b1;
    wait_clk(2 * H);
    check("miso_idle", 32'(miso), 32'h0);
  endtask

  // ARM, idle, DISARM in one frame; the +4 keeps the armed span off a tick boundary.
  task automatic arm_window(input logic [CH-1:0] v, input int n);
    int ca;
    int ticks;
    logic [7:0] rx;
    pin_values = v;
    cs_low();
    spi_byte(8'h01, 8, 1'b0, rx);
    check("arm_miso", 32'(rx), 32'h0);
    ca = last_rise;
    wait_clk(n * DIV + 4);
    spi_byte(8'h02, 8, 1'b0, rx);
    check("disarm_miso", 32'(rx), 32'h0);
    ticks = (last_rise - ca) / DIV;
    cs_high();
    movf = 1'b0;
    for (int t = 0; t < ticks; t++) begin
      if (mq.size() < DEP) mq.push_back(v);
      else movf = 1'b1;
    end
    check_state("arm");
  endtask

  // READ frame: every byte boundary (command end included) loads a byte; the first byte of a sample pops.
  task automatic read_frame(input int ndata, input bit glitch, input int prefix);
    logic [7:0]    rx;
    logic [7:0]    expb;
    logic [CH-1:0] hold;
    cs_low();
    if (prefix >= 0) begin
      spi_byte(8'(prefix), 8, glitch, rx);
      check("prefix_miso", 32'(rx), 32'h0);
    end
    spi_byte(8'h03, 8, glitch, rx);
    check("read_cmd_miso", 32'(rx), 32'h0);
    hold = '0;
    for (int j = 0; j <= ndata; j++) begin
      if (j % NB == 0) hold = (mq.size() > 0) ? mq.pop_front() : '0;
      expb = 8'(hold >> (8 * (NB - 1 - (j % NB))));
      if (j < ndata) begin
        spi_byte(8'($urandom), 8, glitch, rx);
        check($sformatf("data%0d", j), 32'(rx), 32'(expb));
      end
    end
    cs_high();
    check_state("read");
  endtask

  initial begin
    logic [7:0] rx;
    int         unk;

    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    wait_clk(100);
    check("idle_level", 32'(fifo_level), 32'h0);

    arm_window(CH'($urandom), $urandom_range(0, 4));
    read_frame(2 * mq.size() + 2, 1'b0, -1);

    arm_window(CH'($urandom), $urandom_range(10, 14));

    cs_low();
    spi_byte(8'h03, 4, 1'b0, rx);
    cs_high();
    check_state("partial");

    read_frame(19, 1'b1, -1);
    arm_window(CH'($urandom), 0);

`ifdef SPI_STATUS_EN
    cs_low();
    spi_byte(8'h04, 8, 1'b0, rx);
    check("status_cmd_miso", 32'(rx), 32'h0);
    for (int s = 0; s < 3; s++) begin
      spi_byte(8'($urandom), 8, 1'b0, rx);
      check("status_byte", 32'(rx), 32'({movf, 1'b0, 6'(mq.size())}));
    end
    cs_high();
    check_state("status");
    unk = $urandom_range(5, 255);
`else
    read_frame(3, 1'b1, 4);
    unk = $urandom_range(4, 255);
`endif
    read_frame(5, 1'b0, unk);

    for (int it = 0; it < 5; it++) begin
      arm_window(CH'($urandom), $urandom_range(0, 8));
      read_frame($urandom_range(1, 30), it[0], -1);
    end
    read_frame(2 * mq.size() + 2, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
